uart_fifo_mapper: RTL and testbench

Parametrised successor to the single-byte UART mapper on the 6502 bus. It buffers received UART bytes in a DEPTH-entry FIFO and exposes four byte-wide registers: DATA, STATUS, COUNT and CTRL. It drives a level IRQ based on a programmable occupancy threshold and on a sticky overflow flag. It sits between sdl_uart (or the hardware UART RX) and the CPU data-bus mux, decoded by the top-level address logic.

---
 rtl/uart_fifo_mapper.sv | 151 +++++++++++++++
 tb/tb_uart_fifo_mapper.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_mapper.sv
// rtl/uart_fifo_mapper.sv - UART receive FIFO with byte-wide register window and threshold IRQ
//
// Purpose: buffers received UART bytes in a DEPTH-entry FIFO and exposes them to
// the CPU through four byte registers (DATA, STATUS, COUNT, CTRL). A registered
// level IRQ fires when occupancy reaches the programmable threshold or when the
// sticky overflow flag is set.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   uart_byte       received byte, valid with uart_byte_ready
//   uart_byte_ready one-cycle push strobe
//   cs              register window select
//   we              CPU write enable (1 write, 0 read)
//   reg_sel         0 DATA, 1 STATUS, 2 COUNT, 3 CTRL
//   wdata           CPU write data
//   rdata           combinational read data (0 when not reading)
//   irq             registered level interrupt, active high
module uart_fifo_mapper #(
   parameter int DEPTH      = 16,
   parameter int IRQ_THRESH = 1,
   parameter bit IRQ_EN_RST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] uart_byte,
   input  logic       uart_byte_ready,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] reg_sel,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [3:0]    THRESH_RST = 4'(IRQ_THRESH);

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          irq_en_q, irq_en_d;
   logic [3:0]    thresh_q, thresh_d;
   logic          irq_q, irq_d;

   logic empty, full;
   logic rd_acc, wr_acc;
   logic push, pop, flush;
   logic do_push, do_pop;
   logic ovf_set, ovf_clr, ctrl_wr;

   // wdata[3] has no function in any register.
   logic unused_wdata;
   assign unused_wdata = wdata[3];

   assign empty  = (count_q == '0);
   assign full   = (count_q == DEPTH_C);
   assign rd_acc = cs & ~we;
   assign wr_acc = cs & we;

   assign push    = uart_byte_ready;
   assign pop     = rd_acc & (reg_sel == REG_DATA) & ~empty;
   assign ctrl_wr = wr_acc & (reg_sel == REG_CTRL);
   assign flush   = ctrl_wr & wdata[1];

   // A push into a full FIFO still succeeds when a pop frees the head slot in
   // the same cycle. Flush overrides both and suppresses the overflow.
   assign do_push = push & (~full | pop) & ~flush;
   assign do_pop  = pop & ~flush;
   assign ovf_set = push & full & ~pop & ~flush;
   assign ovf_clr = wr_acc & (reg_sel == REG_STATUS) & wdata[2];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      irq_en_d   = irq_en_q;
      thresh_d   = thresh_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (do_pop && !do_push) count_d = count_q - CW'(1);
      end

      // Set has priority over a simultaneous write-one-to-clear.
      if (ovf_set)      overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;

      if (ctrl_wr) begin
         irq_en_d = wdata[0];
         thresh_d = (wdata[7:4] == 4'd0) ? 4'd1 : wdata[7:4];
      end

      irq_d = irq_en_d & ((8'(count_d) >= 8'(thresh_d)) | overflow_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         irq_en_q   <= IRQ_EN_RST;
         thresh_q   <= THRESH_RST;
         irq_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         irq_en_q   <= irq_en_d;
         thresh_q   <= thresh_d;
         irq_q      <= irq_d;
      end
   end

   // Storage is not reset; occupancy and pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= uart_byte;
   end

   always_comb begin
      rdata = 8'h00;
      if (rd_acc) begin
         case (reg_sel)
            REG_DATA:   rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
            REG_STATUS: rdata = {4'b0000, irq_q, overflow_q, full, ~empty};
            2'd2:       rdata = 8'(count_q);
            default:    rdata = {thresh_q, 3'b000, irq_en_q};
         endcase
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_uart_fifo_mapper.sv
// tb/tb_uart_fifo_mapper.sv - self-checking bench for uart_fifo_mapper
module tb_uart_fifo_mapper;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] uart_byte = 8'h00;
   logic       uart_byte_ready = 1'b0;
   logic       cs = 1'b0;
   logic       we = 1'b0;
   logic [1:0] reg_sel = 2'd0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       irq;

   uart_fifo_mapper #(
      .DEPTH      (DEPTH),
      .IRQ_THRESH (1),
      .IRQ_EN_RST (1'b1)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .uart_byte       (uart_byte),
      .uart_byte_ready (uart_byte_ready),
      .cs              (cs),
      .we              (we),
      .reg_sel         (reg_sel),
      .wdata           (wdata),
      .rdata           (rdata),
      .irq             (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: byte queue plus the architectural flags.
   logic [7:0] m_q[$];
   logic       m_ovf;
   logic       m_irq_en;
   logic [3:0] m_thresh;
   logic       m_irq;

   logic [7:0] rd_obs;
   logic [7:0] rd_exp;

   task automatic model_reset();
      m_q.delete();
      m_ovf    = 1'b0;
      m_irq_en = 1'b1;
      m_thresh = 4'd1;
      m_irq    = 1'b0;
   endtask

   function automatic logic [7:0] model_read(input logic c, input logic w, input logic [1:0] s);
      if (!c || w) return 8'h00;
      case (s)
         2'd0:    return (m_q.size() != 0) ? m_q[0] : 8'h00;
         2'd1:    return {4'b0000, m_irq, m_ovf, m_q.size() == DEPTH, m_q.size() != 0};
         2'd2:    return 8'(m_q.size());
         default: return {m_thresh, 3'b000, m_irq_en};
      endcase
   endfunction

   task automatic model_step(input logic p, input logic [7:0] b, input logic c, input logic w,
                             input logic [1:0] s, input logic [7:0] wd);
      logic rd, flush, ovf_set;
      rd      = c && !w && s == 2'd0 && m_q.size() != 0;
      flush   = c && w && s == 2'd3 && wd[1];
      ovf_set = 1'b0;
      if (flush) begin
         m_q.delete();
      end else begin
         if (rd) void'(m_q.pop_front());
         if (p) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else ovf_set = 1'b1;
         end
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (c && w && s == 2'd1 && wd[2]) m_ovf = 1'b0;
      if (c && w && s == 2'd3) begin
         m_irq_en = wd[0];
         m_thresh = (wd[7:4] == 4'd0) ? 4'd1 : wd[7:4];
      end
      m_irq = m_irq_en && ((m_q.size() >= int'(m_thresh)) || m_ovf);
   endtask

   // One bus cycle: inputs applied after posedge, rdata sampled at negedge,
   // model advanced at the edge, irq observable #1 after it.
   task automatic cycle(input logic p, input logic [7:0] b, input logic c, input logic w,
                        input logic [1:0] s, input logic [7:0] wd);
      uart_byte_ready = p;
      uart_byte       = b;
      cs              = c;
      we              = w;
      reg_sel         = s;
      wdata           = wd;
      @(negedge clk);
      rd_obs = rdata;
      rd_exp = model_read(c, w, s);
      @(posedge clk);
      model_step(p, b, c, w, s, wd);
      #1;
      uart_byte_ready = 1'b0;
      cs              = 1'b0;
      we              = 1'b0;
   endtask

   task automatic push_b(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, 1'b0, 2'd0, 8'h00);
   endtask

   task automatic read_reg(input logic [1:0] s);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, s, 8'h00);
   endtask

   task automatic write_reg(input logic [1:0] s, input logic [7:0] wd);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, s, wd);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cs = 1'b1; we = 1'b0; reg_sel = 2'd2;
      #1;
      n_checks++; if (rdata !== 8'h00) $display("FAIL reset_count: got %h expected 00", rdata); else n_pass++;
      reg_sel = 2'd1;
      #1;
      n_checks++; if (rdata !== 8'h00) $display("FAIL reset_status: got %h expected 00", rdata); else n_pass++;
      reg_sel = 2'd3;
      #1;
      n_checks++; if (rdata !== 8'h11) $display("FAIL reset_ctrl: got %h expected 11", rdata); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
      cs = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single_byte();
      push_b(8'h41);
      n_checks++; if (irq !== 1'b1) $display("FAIL single_irq_set: got %b expected 1", irq); else n_pass++;
      read_reg(2'd1);
      n_checks++; if (rd_obs !== 8'h09) $display("FAIL single_status: got %h expected 09", rd_obs); else n_pass++;
      read_reg(2'd2);
      n_checks++; if (rd_obs !== 8'h01) $display("FAIL single_count: got %h expected 01", rd_obs); else n_pass++;
      read_reg(2'd0);
      n_checks++; if (rd_obs !== 8'h41) $display("FAIL single_data: got %h expected 41", rd_obs); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL single_irq_clr: got %b expected 0", irq); else n_pass++;
      read_reg(2'd1);
      n_checks++; if (rd_obs !== 8'h00) $display("FAIL single_status_empty: got %h expected 00", rd_obs); else n_pass++;
      read_reg(2'd2);
      n_checks++; if (rd_obs !== 8'h00) $display("FAIL single_count_empty: got %h expected 00", rd_obs); else n_pass++;
   endtask

   task automatic test_threshold();
      write_reg(2'd3, 8'h41);
      read_reg(2'd3);
      n_checks++; if (rd_obs !== 8'h41) $display("FAIL thresh_ctrl_rd: got %h expected 41", rd_obs); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         push_b(8'h10 + 8'(i));
         n_checks++; if (irq !== 1'b0) $display("FAIL thresh_below_%0d: got %b expected 0", i, irq); else n_pass++;
      end
      push_b(8'h13);
      n_checks++; if (irq !== 1'b1) $display("FAIL thresh_reached: got %b expected 1", irq); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         read_reg(2'd0);
         n_checks++; if (rd_obs !== 8'h10 + 8'(i)) $display("FAIL thresh_data_%0d: got %h expected %h", i, rd_obs, 8'h10 + 8'(i)); else n_pass++;
         n_checks++; if (irq !== m_irq) $display("FAIL thresh_irq_%0d: got %b expected %b", i, irq, m_irq); else n_pass++;
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i <= 16; i++) push_b(8'(i));
      read_reg(2'd2);
      n_checks++; if (rd_obs !== 8'd16) $display("FAIL ovf_count: got %h expected 10", rd_obs); else n_pass++;
      read_reg(2'd1);
      n_checks++; if (rd_obs !== 8'h0F) $display("FAIL ovf_status: got %h expected 0f", rd_obs); else n_pass++;
      write_reg(2'd1, 8'h04);
      read_reg(2'd1);
      n_checks++; if (rd_obs !== 8'h0B) $display("FAIL ovf_w1c_status: got %h expected 0b", rd_obs); else n_pass++;
      n_checks++; if (irq !== 1'b1) $display("FAIL ovf_w1c_irq: got %b expected 1", irq); else n_pass++;
   endtask

   task automatic test_full_push_pop();
      cycle(1'b1, 8'hAA, 1'b1, 1'b0, 2'd0, 8'h00);
      n_checks++; if (rd_obs !== 8'h00) $display("FAIL fullpp_head: got %h expected 00", rd_obs); else n_pass++;
      read_reg(2'd2);
      n_checks++; if (rd_obs !== 8'd16) $display("FAIL fullpp_count: got %h expected 10", rd_obs); else n_pass++;
      read_reg(2'd1);
      n_checks++; if (rd_obs !== 8'h0B) $display("FAIL fullpp_status: got %h expected 0b", rd_obs); else n_pass++;
      for (int i = 1; i <= 16; i++) begin
         read_reg(2'd0);
         rd_exp = (i == 16) ? 8'hAA : 8'(i);
         n_checks++; if (rd_obs !== rd_exp) $display("FAIL fullpp_drain_%0d: got %h expected %h", i, rd_obs, rd_exp); else n_pass++;
      end
      n_checks++; if (irq !== 1'b0) $display("FAIL fullpp_irq_drained: got %b expected 0", irq); else n_pass++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) push_b(8'($urandom));
      n_checks++; if (irq !== 1'b1) $display("FAIL flush_pre_irq: got %b expected 1", irq); else n_pass++;
      cycle(1'b1, 8'h55, 1'b1, 1'b1, 2'd3, 8'h13);
      n_checks++; if (irq !== 1'b0) $display("FAIL flush_irq: got %b expected 0", irq); else n_pass++;
      read_reg(2'd2);
      n_checks++; if (rd_obs !== 8'h00) $display("FAIL flush_count: got %h expected 00", rd_obs); else n_pass++;
      read_reg(2'd1);
      n_checks++; if (rd_obs !== 8'h00) $display("FAIL flush_status: got %h expected 00", rd_obs); else n_pass++;
      read_reg(2'd3);
      n_checks++; if (rd_obs !== 8'h11) $display("FAIL flush_ctrl: got %h expected 11", rd_obs); else n_pass++;
      read_reg(2'd0);
      n_checks++; if (rd_obs !== 8'h00) $display("FAIL flush_data: got %h expected 00", rd_obs); else n_pass++;
   endtask

   task automatic test_random();
      int bad_rd;
      int bad_irq;
      bad_rd  = 0;
      bad_irq = 0;
      for (int i = 0; i < 400; i++) begin
         logic p, c, w;
         p = ($urandom_range(0, 99) < 55);
         c = ($urandom_range(0, 99) < 60);
         w = ($urandom_range(0, 99) < 30);
         cycle(p, 8'($urandom), c, w, 2'($urandom), 8'($urandom));
         n_checks++;
         if (rd_obs !== rd_exp) begin
            bad_rd++;
            if (bad_rd <= 5) $display("FAIL rand_rdata_%0d: got %h expected %h", i, rd_obs, rd_exp);
         end else n_pass++;
         n_checks++;
         if (irq !== m_irq) begin
            bad_irq++;
            if (bad_irq <= 5) $display("FAIL rand_irq_%0d: got %b expected %b", i, irq, m_irq);
         end else n_pass++;
      end
   endtask

   task automatic test_wrap_and_reset();
      write_reg(2'd3, 8'h13);
      write_reg(2'd1, 8'h04);
      for (int i = 0; i < 40; i++) begin
         push_b(8'h20 + 8'(i));
         n_checks++; if (irq !== m_irq) $display("FAIL wrap_irq_%0d: got %b expected %b", i, irq, m_irq); else n_pass++;
         read_reg(2'd0);
         n_checks++; if (rd_obs !== 8'h20 + 8'(i)) $display("FAIL wrap_data_%0d: got %h expected %h", i, rd_obs, 8'h20 + 8'(i)); else n_pass++;
      end
      write_reg(2'd3, 8'h51);
      for (int i = 0; i < 6; i++) push_b(8'($urandom));
      n_checks++; if (irq !== 1'b1) $display("FAIL midrst_pre_irq: got %b expected 1", irq); else n_pass++;
      #2;
      rst_n = 1'b0;
      model_reset();
      cs = 1'b1; we = 1'b0; reg_sel = 2'd2;
      #1;
      n_checks++; if (rdata !== 8'h00) $display("FAIL midrst_count: got %h expected 00", rdata); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL midrst_irq: got %b expected 0", irq); else n_pass++;
      reg_sel = 2'd3;
      #1;
      n_checks++; if (rdata !== 8'h11) $display("FAIL midrst_ctrl: got %h expected 11", rdata); else n_pass++;
      cs = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      read_reg(2'd0);
      n_checks++; if (rd_obs !== 8'h00) $display("FAIL midrst_data: got %h expected 00", rd_obs); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_threshold();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_random();
      test_wrap_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
